// File: rtl/mfp_ahb_rojo_master.sv
// AHB-lite master that carries one valid/ready command at a time onto the bus.
// Define ROJO_AUTO_ACK_EN to add the rojobot BOTINFO read / INTACK handshake sequencer.
module mfp_ahb_rojo_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        bot_updt,
  output logic [31:0] botinfo,
  output logic        botinfo_valid,
  output logic        upd_overrun
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0] lat_addr, lat_wdata;
  logic        lat_write, lat_auto;

  logic        auto_req;
  logic [31:0] auto_addr, auto_wdata;
  logic        auto_write;
  logic        cmd_acc, auto_acc, data_done;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // The sequencer outranks the command port whenever it wants the bus.
  always_comb begin
    state_nxt = state;
    cmd_acc   = 1'b0;
    auto_acc  = 1'b0;
    data_done = 1'b0;
    case (state)
      IDLE: begin
        if (auto_req) begin
          auto_acc  = 1'b1;
          state_nxt = ADDR;
        end else if (cmd_valid) begin
          cmd_acc   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: if (HREADY) state_nxt = DATA;
      DATA: if (HREADY) begin
        data_done = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign HTRANS    = (state == ADDR) ? TR_NONSEQ : TR_IDLE;
  assign HADDR     = lat_addr;
  assign HWRITE    = lat_write;
  assign HSIZE     = 3'b010;
  assign HWDATA    = (state == DATA && lat_write) ? lat_wdata : 32'd0;
  assign cmd_ready = HRESETn && (state == IDLE) && !auto_req;
  assign rsp_valid = (state == RESP) && !lat_auto;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_write <= 1'b0;
      lat_auto  <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (cmd_acc) begin
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
        lat_write <= cmd_write;
        lat_auto  <= 1'b0;
      end else if (auto_acc) begin
        lat_addr  <= auto_addr;
        lat_wdata <= auto_wdata;
        lat_write <= auto_write;
        lat_auto  <= 1'b1;
      end
      if (data_done && !lat_auto) begin
        rsp_rdata <= lat_write ? 32'd0 : HRDATA;
        rsp_err   <= HRESP;
      end
    end
  end

`ifdef ROJO_AUTO_ACK_EN
  localparam logic [31:0] BOTINFO_ADDR = 32'h1f80000C;
  localparam logic [31:0] INTACK_ADDR  = 32'h1f800018;

  logic        updt_q, pending, rise, auto_done;
  logic [1:0]  step;
  logic [31:0] shadow;

  assign rise      = bot_updt && !updt_q;
  assign auto_req  = pending || rise;
  assign auto_done = (state == RESP) && lat_auto && (step == 2'd2);

  // step 0: read BOTINFO, 1: INTACK=1, 2: INTACK=0
  always_comb begin
    auto_addr  = (step == 2'd0) ? BOTINFO_ADDR : INTACK_ADDR;
    auto_write = (step != 2'd0);
    auto_wdata = (step == 2'd1) ? 32'd1 : 32'd0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      updt_q        <= 1'b0;
      pending       <= 1'b0;
      step          <= 2'd0;
      shadow        <= 32'd0;
      botinfo       <= 32'd0;
      botinfo_valid <= 1'b0;
      upd_overrun   <= 1'b0;
    end else begin
      updt_q        <= bot_updt;
      // an edge arriving while a sequence is owed is folded into that sequence
      pending       <= (pending && !auto_done) || (rise && !pending);
      botinfo_valid <= auto_done;
      if (rise && pending) upd_overrun <= 1'b1;
      if (data_done && lat_auto && step == 2'd0) shadow <= HRDATA;
      if (auto_done) begin
        botinfo <= shadow;
        step    <= 2'd0;
      end else if (state == RESP && lat_auto) begin
        step <= step + 2'd1;
      end
    end
  end
`else
  logic unused_bot_updt;
  assign unused_bot_updt = bot_updt;
  assign auto_req      = 1'b0;
  assign auto_addr     = 32'd0;
  assign auto_wdata    = 32'd0;
  assign auto_write    = 1'b0;
  assign botinfo       = 32'd0;
  assign botinfo_valid = 1'b0;
  assign upd_overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_mfp_ahb_rojo_master.sv
// Directed bench for mfp_ahb_rojo_master: vector table of single commands plus
// hand sequences for reset mid-transfer and (with ROJO_AUTO_ACK_EN) the auto sequencer.
`timescale 1ns/1ps
module tb_mfp_ahb_rojo_master;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, botinfo;
  logic        rsp_valid, rsp_err, bot_updt, botinfo_valid, upd_overrun;

  always #5 HCLK = ~HCLK;

  mfp_ahb_rojo_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bot_updt(bot_updt), .botinfo(botinfo),
    .botinfo_valid(botinfo_valid), .upd_overrun(upd_overrun)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata, hrdata;
    logic        hresp;
    int          aw, dw;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Bus log: completed address phases and the HWDATA of each completed data phase.
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_wdata[$];
  int rsp_pulses = 0, bi_pulses = 0;
  bit in_data = 1'b0;

  always @(negedge HCLK) begin
    #2;
    if (!HRESETn) in_data = 1'b0;
    else begin
      if (rsp_valid) rsp_pulses++;
      if (botinfo_valid) bi_pulses++;
      if (in_data && HREADY) begin
        log_wdata.push_back(HWDATA);
        in_data = 1'b0;
      end else if (HTRANS == 2'b10 && HREADY) begin
        log_addr.push_back(HADDR);
        log_wr.push_back(HWRITE);
        in_data = 1'b1;
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit updt, input string tag);
    int ns = 0, dc = 0, aw = 0, dw = 0, lat = 0;
    bit acc = 1'b0, got = 1'b0, addr_ok = 1'b1, wd_ok = 1'b1;
    logic [31:0] rd = 32'd0;
    logic        er = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h00A51234;
    if (updt) bot_updt = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      #1;
      if (cmd_ready) acc = 1'b1;
      else @(negedge HCLK);
    end
    check({tag, " accepted"}, 32'(acc), 32'd1);
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge HCLK);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (HTRANS == 2'b10) begin
        ns++;
        if (HADDR !== v.addr || HWRITE !== v.wr) addr_ok = 1'b0;
        HREADY = (aw == v.aw);
        aw++;
      end else if (rsp_valid) begin
        got = 1'b1; lat = c - 1; rd = rsp_rdata; er = rsp_err;
      end else begin
        dc++;
        if (v.wr && HWDATA !== v.wdata) wd_ok = 1'b0;
        HRDATA = v.hrdata; HRESP = v.hresp;
        HREADY = (dw == v.dw);
        dw++;
      end
      if (!got) @(negedge HCLK);
    end
    HREADY = 1'b1; HRESP = 1'b0;
    check({tag, " rsp_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " nonseq_cycles"}, 32'(ns), 32'(v.aw + 1));
    check({tag, " data_cycles"}, 32'(dc), 32'(v.dw + 1));
    check({tag, " rsp_rdata"}, rd, v.exp_rdata);
    check({tag, " rsp_err"}, 32'(er), 32'(v.exp_err));
    check({tag, " haddr_hwrite"}, 32'(addr_ok), 32'd1);
    check({tag, " hwdata"}, 32'(wd_ok), 32'd1);
    @(negedge HCLK); #1;
    check({tag, " rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, " back_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp0, bi0, st;
    vec_t av;
    vecs[0] = '{1'b0, 32'h1f80000C, 32'h0,        32'h00A51234, 1'b0, 0, 0, 32'h00A51234, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h1f800010, 32'h00000033, 32'hDEADBEEF, 1'b0, 0, 3, 32'h0,        1'b0, 5};
    vecs[2] = '{1'b0, 32'h12345678, 32'h0,        32'hCAFEF00D, 1'b0, 2, 1, 32'hCAFEF00D, 1'b0, 5};
    vecs[3] = '{1'b1, 32'h1f800018, 32'hFFFFFFFF, 32'h0BADF00D, 1'b1, 1, 0, 32'h0,        1'b1, 3};
    vecs[4] = '{1'b0, 32'h00000000, 32'h0,        32'h5A5A5A5A, 1'b0, 0, 0, 32'h5A5A5A5A, 1'b0, 2};
    vecs[5] = '{1'b0, 32'h1f800014, 32'h0,        32'hBADBAD00, 1'b1, 0, 1, 32'hBADBAD00, 1'b1, 3};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    HRDATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0; bot_updt = 1'b0;

    repeat (2) @(negedge HCLK);
    #1;
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset htrans", 32'(HTRANS), 32'd0);
    check("reset haddr", HADDR, 32'd0);
    check("reset hwdata", HWDATA, 32'd0);
    check("reset rsp", {29'd0, rsp_valid, rsp_err, HWRITE}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset bot outs", {30'd0, botinfo_valid, upd_overrun}, 32'd0);
    check("reset botinfo", botinfo, 32'd0);
    check("hsize word", 32'(HSIZE), 32'd2);
    HRESETn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset while the write sits in its data phase.
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1f800010; cmd_wdata = 32'h77;
    HREADY = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("rst_mid addr phase", 32'(HTRANS), 32'd2);
    @(negedge HCLK);
    check("rst_mid data phase hwdata", HWDATA, 32'h77);
    HREADY = 1'b0; HRESETn = 1'b0;
    #1;
    check("rst_mid cmd_ready in reset", 32'(cmd_ready), 32'd0);
    @(negedge HCLK); #1;
    check("rst_mid htrans", 32'(HTRANS), 32'd0);
    check("rst_mid haddr", HADDR, 32'd0);
    check("rst_mid hwdata", HWDATA, 32'd0);
    check("rst_mid flags", {29'd0, rsp_valid, rsp_err, HWRITE}, 32'd0);
    check("rst_mid rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mid bot outs", {30'd0, botinfo_valid, upd_overrun}, 32'd0);
    HRESETn = 1'b1; HREADY = 1'b1;
    rp0 = rsp_pulses;
    repeat (4) @(negedge HCLK);
    #3;
    check("rst_mid no rsp pulse", 32'(rsp_pulses - rp0), 32'd0);
    check("rst_mid idle after", 32'(cmd_ready), 32'd1);
    run_vec(vecs[0], 1'b0, "post_reset");

`ifdef ROJO_AUTO_ACK_EN
    // Update edge in the same cycle as a command: auto sequence runs first.
    log_addr.delete(); log_wr.delete(); log_wdata.delete();
    rp0 = rsp_pulses; bi0 = bi_pulses;
    av = '{1'b0, 32'h1f800010, 32'h0, 32'h00000011, 1'b0, 0, 0, 32'h00000011, 1'b0, 2};
    run_vec(av, 1'b1, "auto_cmd");
    check("auto transfer count", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() >= 4 && log_wdata.size() >= 3) begin
      check("auto t0 addr", log_addr[0], 32'h1f80000C);
      check("auto t0 write", 32'(log_wr[0]), 32'd0);
      check("auto t1 addr", log_addr[1], 32'h1f800018);
      check("auto t1 wdata", log_wdata[1], 32'd1);
      check("auto t2 addr", log_addr[2], 32'h1f800018);
      check("auto t2 wdata", log_wdata[2], 32'd0);
      check("auto then cmd addr", log_addr[3], 32'h1f800010);
    end
    check("auto botinfo", botinfo, 32'h00A51234);
    check("auto botinfo_valid pulses", 32'(bi_pulses - bi0), 32'd1);
    check("auto rsp pulses", 32'(rsp_pulses - rp0), 32'd1);
    check("auto no overrun", 32'(upd_overrun), 32'd0);

    // Second edge during the INTACK=1 write merges and flags an overrun.
    bot_updt = 1'b0;
    repeat (2) @(negedge HCLK);
    log_addr.delete(); log_wr.delete(); log_wdata.delete();
    bi0 = bi_pulses; st = 0;
    bot_updt = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge HCLK); #3;
      if (st == 0 && log_addr.size() == 2) begin
        bot_updt = 1'b0; st = 1;
      end else if (st == 1) begin
        bot_updt = 1'b1; st = 2;
      end
    end
    check("ovr toggled", 32'(st), 32'd2);
    check("ovr transfer count", 32'(log_addr.size()), 32'd3);
    check("ovr upd_overrun", 32'(upd_overrun), 32'd1);
    check("ovr botinfo_valid pulses", 32'(bi_pulses - bi0), 32'd1);
    check("ovr idle after", 32'(cmd_ready), 32'd1);
`else
    // Without the sequencer bot_updt has no effect.
    @(negedge HCLK);
    bot_updt = 1'b1;
    #1;
    check("noauto cmd_ready on edge", 32'(cmd_ready), 32'd1);
    bi0 = bi_pulses;
    repeat (4) @(negedge HCLK);
    #3;
    check("noauto htrans", 32'(HTRANS), 32'd0);
    check("noauto bot outs", {30'd0, botinfo_valid, upd_overrun}, 32'd0);
    check("noauto botinfo", botinfo, 32'd0);
    check("noauto botinfo pulses", 32'(bi_pulses - bi0), 32'd0);
    bot_updt = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
